// File: rtl/dice_roll_counter.sv
// Electronic die: spins through [min,max] while Roll is held, then decelerates
// over SLOW_STEPS progressively longer intervals before showing the result.
module dice_roll_counter #(
  parameter int unsigned SLOW_STEPS = 8,
  parameter int unsigned BASE_DIV   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_min,
  input  logic [6:0] i_max,
  input  logic       i_roll,
  output logic [6:0] o_value,
  output logic       o_rolling,
  output logic       o_done,
  output logic       o_range_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SPIN = 2'd1,
    ST_SLOW = 2'd2,
    ST_SHOW = 2'd3
  } state_t;

  localparam logic [3:0] C_LAST_STEP = 4'(SLOW_STEPS - 1);

  state_t     r_state;
  logic [6:0] r_value;
  logic [6:0] r_min;
  logic [6:0] r_max;
  logic [7:0] r_div;
  logic [3:0] r_step;
  logic       r_rolling;
  logic       r_done;
  logic       r_range_err;

  state_t     w_state_nx;
  logic [6:0] w_value_nx;
  logic [6:0] w_min_nx;
  logic [6:0] w_max_nx;
  logic [7:0] w_div_nx;
  logic [3:0] w_step_nx;
  logic       w_rolling_nx;
  logic       w_done_nx;
  logic       w_range_err_nx;

  // Out-of-range values (above hi) wrap straight back to lo.
  function automatic logic [6:0] f_advance(input logic [6:0] value,
                                           input logic [6:0] lo,
                                           input logic [6:0] hi);
    logic [6:0] res;
    if (value >= hi) begin
      res = lo;
    end else begin
      res = value + 7'd1;
    end
    return res;
  endfunction

  // Last divider count of the current slow interval: BASE_DIV*(step+1)-1.
  function automatic logic [7:0] f_slot_end(input logic [3:0] step);
    logic [3:0]  nxt;
    logic [11:0] prod;
    nxt  = step + 4'd1;
    prod = 12'(BASE_DIV) * {8'd0, nxt};
    return 8'(prod - 12'd1);
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    w_state_nx     = r_state;
    w_value_nx     = r_value;
    w_min_nx       = r_min;
    w_max_nx       = r_max;
    w_div_nx       = r_div;
    w_step_nx      = r_step;
    w_done_nx      = 1'b0;
    w_range_err_nx = 1'b0;
    case (r_state)
      ST_IDLE, ST_SHOW: begin
        if (i_roll) begin
          if (i_min <= i_max) begin
            w_min_nx   = i_min;
            w_max_nx   = i_max;
            w_value_nx = i_min;
            w_state_nx = ST_SPIN;
          end else begin
            w_range_err_nx = 1'b1;
          end
        end else begin
          w_state_nx = r_state;
        end
      end
      ST_SPIN: begin
        if (i_roll) begin
          w_value_nx = f_advance(r_value, r_min, r_max);
        end else begin
          w_state_nx = ST_SLOW;
          w_div_nx   = 8'd0;
          w_step_nx  = 4'd0;
        end
      end
      ST_SLOW: begin
        // A renewed Roll wins over a final advance landing on the same edge.
        if (i_roll) begin
          w_state_nx = ST_SPIN;
        end else if (r_div == f_slot_end(r_step)) begin
          w_value_nx = f_advance(r_value, r_min, r_max);
          w_div_nx   = 8'd0;
          w_step_nx  = r_step + 4'd1;
          if (r_step == C_LAST_STEP) begin
            w_state_nx = ST_SHOW;
            w_done_nx  = 1'b1;
          end else begin
            w_state_nx = ST_SLOW;
          end
        end else begin
          w_div_nx = r_div + 8'd1;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
    w_rolling_nx = (w_state_nx == ST_SPIN) || (w_state_nx == ST_SLOW);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_value     <= 7'd0;
      r_min       <= 7'd0;
      r_max       <= 7'd0;
      r_div       <= 8'd0;
      r_step      <= 4'd0;
      r_rolling   <= 1'b0;
      r_done      <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_value     <= w_value_nx;
      r_min       <= w_min_nx;
      r_max       <= w_max_nx;
      r_div       <= w_div_nx;
      r_step      <= w_step_nx;
      r_rolling   <= w_rolling_nx;
      r_done      <= w_done_nx;
      r_range_err <= w_range_err_nx;
    end
  end

  assign o_value     = r_value;
  assign o_rolling   = r_rolling;
  assign o_done      = r_done;
  assign o_range_err = r_range_err;

endmodule

// File: doc/dice_roll_counter.md
DICE_ROLL_COUNTER -- requirements
Module: dice_roll_counter

Interface
REQ-001 Parameter SLOW_STEPS, default 8: number of decelerating advances after Roll release; legal range 1..15.
REQ-002 Parameter BASE_DIV, default 4: base clock divisor for deceleration; legal range 1..15.
REQ-003 Clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Rst_n  input  1  asynchronous, active-low reset.
REQ-005 Min  input  7  lowest face value of the selected die (unsigned).
REQ-006 Max  input  7  highest face value of the selected die (unsigned).
REQ-007 Roll  input  1  roll request, level, already synchronous to Clk.
REQ-008 Value  output  7  current or final die value, registered.
REQ-009 Rolling  output  1  high while in SPIN or SLOW, registered.
REQ-010 Done  output  1  one-cycle pulse when a result becomes final.
REQ-011 Range_Err  output  1  one-cycle pulse when a roll is refused because Min > Max.

Function
REQ-012 States SHALL be IDLE, SPIN, SLOW and SHOW; Rolling = 1 exactly in SPIN and SLOW.
REQ-013 IDLE/SHOW, Roll=1, Min<=Max: SHALL capture Min/Max into internal min_r/max_r, set Value=Min and go to SPIN on the same edge.
REQ-014 IDLE/SHOW, Roll=1, Min>Max: SHALL stay in the current state with Value unchanged and pulse Range_Err for 1 cycle; it repeats every cycle while the condition holds.
REQ-015 Advance rule: Value >= max_r gives min_r, otherwise Value+1. Out-of-range values therefore wrap to min_r.
REQ-016 Arithmetic width: all values are 7-bit unsigned with no overflow; max_r <= 127 is guaranteed by width.
REQ-017 Min/Max changes after capture SHALL be ignored until the next capture.
REQ-018 SPIN: SHALL advance Value every cycle after entry while Roll=1.
REQ-019 SPIN, Roll=0: SHALL go to SLOW, clear the divider counter div and step counter step, and not advance on that edge.
REQ-020 SLOW: div SHALL increment each cycle.
REQ-021 SLOW, div = BASE_DIV*(step+1)-1: SHALL advance Value, clear div and increment step.
REQ-022 SLOW, advance with step = SLOW_STEPS-1: SHALL go to SHOW and drive Done=1 in the following cycle only.
REQ-023 SLOW duration: SLOW SHALL last exactly BASE_DIV*SLOW_STEPS*(SLOW_STEPS+1)/2 cycles, which is 144 with default parameters.
REQ-024 SLOW, Roll=1: SHALL return to SPIN without a recapture and without Done; Value continues from its current value. Roll takes priority over a coincident final advance.
REQ-025 SHOW: SHALL hold Value until a new capture per REQ-013.
REQ-026 Degenerate range min_r = max_r: Value SHALL remain constant; the timing rules are unchanged.
REQ-027 Done and Range_Err SHALL never be asserted together, and neither SHALL be asserted for more than 1 consecutive cycle per event.

Reset
REQ-028 Rst_n=0 SHALL immediately (asynchronously) force state IDLE, Value=0, Rolling=0, Done=0, Range_Err=0, min_r=0, max_r=0, div=0 and step=0.
REQ-029 Reset asserted mid-SPIN or mid-SLOW SHALL abort the roll with no Done pulse.
REQ-030 After Rst_n deasserts, the first capture SHALL occur at the first rising edge with Roll=1.

Verification
REQ-031 Min=1, Max=6, Roll high for 10 cycles from IDLE -> Value sequence 1,2,3,4,5,6,1,2,3,4 and Rolling=1 throughout.
REQ-032 Min=0, Max=9, release Roll with Value=3 -> Value=1 (3+8 wrapped), Done pulses exactly 144 cycles after SLOW entry, and Rolling falls with the SHOW transition.
REQ-033 Min=7, Max=4, Roll pulsed 1 cycle in IDLE -> Range_Err=1 for 1 cycle, Value=0, Rolling=0, state IDLE.
REQ-034 Roll reasserted 20 cycles into SLOW -> SPIN re-entered, Rolling stays 1, no Done pulse, and Value advances each cycle from its held value.
REQ-035 Min=Max=1 roll to completion -> Value=1 constantly and Done after 144 SLOW cycles.
REQ-036 Rst_n pulsed low mid-SLOW, asynchronous to Clk -> all outputs 0 before the next edge, no Done, and the next Roll captures fresh Min/Max.
